uart_mem_bridge: RTL

Parametrised CPU-to-external-memory bridge over a single 8N1 UART link, the next generation of the memory_com bridge. It serialises each CPU load/store into a command frame (command byte, address bytes, store data), then collects the store acknowledge or the load data from the link. It returns the load data sign- or zero-extended to the CPU, and flags timeouts, NAKs and framing errors. It sits between the CPU load/store unit and the off-chip memory host.

---
 rtl/uart_mem_bridge.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: moves CPU loads and stores to an off-chip memory host over
// one 8N1 UART link.
// A store is sent as a command byte, the address bytes and the store data.
// The host then answers with 0x06 (ACK); any other byte counts as a NAK.
// A load is sent as a command byte and the address bytes. The host then
// answers with N data bytes, and the result is sign- or zero-extended.
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   rx / tx               UART receive / transmit lines (idle high)
//   write_enable/read_enable  level request inputs (store wins)
//   address, writeData, size, sign_ext  request fields, latched at acceptance
//   readData              last successful load result
//   mem_done / mem_error  one-cycle completion / failure pulses
//   busy                  request in progress (acceptance until IDLE)
module uart_mem_bridge #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int ADDR_BYTES     = 4,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic                    tx,
    input  logic                    write_enable,
    input  logic                    read_enable,
    input  logic [8*ADDR_BYTES-1:0] address,
    input  logic [8*DATA_BYTES-1:0] writeData,
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    output logic [8*DATA_BYTES-1:0] readData,
    output logic                    mem_done,
    output logic                    mem_error,
    output logic                    busy
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(ADDR_BYTES + DATA_BYTES + 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    ACK_BYTE  = 8'h06;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT_RX = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Data bytes per access: 1 << size, clipped to the data bus width.
    function automatic logic [2:0] nbytes_f(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            2'd2:    n = 3'd4;
            default: n = 3'(DATA_BYTES);
        endcase
        return (n > 3'(DATA_BYTES)) ? 3'(DATA_BYTES) : n;
    endfunction

    // Keep the low n bytes and fill the upper bytes with the extension bit.
    // The loop walks the bytes upwards, so the fill bit is taken from the
    // top kept byte.
    function automatic logic [DW-1:0] extend_f(input logic [DW-1:0] raw,
                                               input logic [2:0] n,
                                               input logic sgn);
        logic [DW-1:0] res;
        logic          fill;
        res  = '0;
        fill = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(n)) begin
                res[8*i +: 8] = raw[8*i +: 8];
                fill          = sgn & raw[8*i+7];
            end else begin
                res[8*i +: 8] = {8{fill}};
            end
        end
        return res;
    endfunction

    state_t          r_state, w_state_next;
    logic            r_rw, r_sign;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [2:0]      r_n;
    logic [BW-1:0]   r_last_idx;
    logic            r_tx;
    logic [8:0]      r_tx_shift;
    logic [CW-1:0]   r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [BW-1:0]   r_tx_idx;
    logic [BW-1:0]   w_nxt_idx;
    logic [7:0]      w_tx_byte;
    logic            r_rx_s1, r_rx_s2, r_rx_s3;
    logic            r_rx_busy;
    logic [CW-1:0]   r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic [2:0]      r_rx_idx;
    logic [DW-1:0]   r_rx_buf, w_ld_raw;
    logic [TW-1:0]   r_to_cnt;
    logic [DW-1:0]   r_rdata;
    logic            r_mem_done, r_mem_error, r_busy;
    logic            w_accept, w_bit_end, w_send_end;
    logic            w_rx_tick, w_rx_stop, w_byte_ok, w_byte_ferr;
    logic            w_ld_last, w_timeout, w_fin, w_fin_err;
    logic [7:0]      w_cmd_in;

    assign w_accept   = write_enable | read_enable;
    assign w_cmd_in   = {write_enable, 5'b00000, size};
    assign w_nxt_idx  = r_tx_idx + BW'(1);
    assign w_bit_end  = (r_tx_cnt == BIT_LAST);
    assign w_send_end = (r_state == S_SEND) && w_bit_end && (r_tx_bit == 4'd9)
                        && (r_tx_idx == r_last_idx);
    // The start bit is sampled at half a bit period; later bits at full periods.
    assign w_rx_tick  = r_rx_busy && ((r_rx_bit == 4'd0) ? (r_rx_cnt == HALF_LAST)
                                                         : (r_rx_cnt == BIT_LAST));
    assign w_rx_stop  = w_rx_tick && (r_rx_bit == 4'd9);
    assign w_byte_ok  = w_rx_stop & r_rx_s2;
    assign w_byte_ferr = w_rx_stop & ~r_rx_s2;
    assign w_ld_last  = (r_rx_idx == (r_n - 3'd1));
    assign w_timeout  = (r_state == S_WAIT_RX) && (r_to_cnt == TO_LAST);

    assign tx        = r_tx;
    assign readData  = r_rdata;
    assign mem_done  = r_mem_done;
    assign mem_error = r_mem_error;
    assign busy      = r_busy;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic and the completion strobes.
    always_comb begin
        w_state_next = r_state;
        w_fin        = 1'b0;
        w_fin_err    = 1'b0;
        case (r_state)
            S_IDLE:    w_state_next = w_accept ? S_SEND : S_IDLE;
            S_SEND:    w_state_next = w_send_end ? S_WAIT_RX : S_SEND;
            S_WAIT_RX: begin
                if (w_byte_ferr || w_timeout) begin
                    w_state_next = S_DONE;
                    w_fin        = 1'b1;
                    w_fin_err    = 1'b1;
                end else if (w_byte_ok && (r_rw || w_ld_last)) begin
                    w_state_next = S_DONE;
                    w_fin        = 1'b1;
                    w_fin_err    = r_rw && (r_rx_shift != ACK_BYTE);
                end else begin
                    w_state_next = S_WAIT_RX;
                end
            end
            S_DONE:    w_state_next = (!write_enable && !read_enable) ? S_IDLE : S_DONE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Latch the request fields when the request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw       <= 1'b0;
            r_sign     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_n        <= 3'd0;
            r_last_idx <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_rw       <= write_enable;
            r_sign     <= sign_ext;
            r_addr     <= address;
            r_wdata    <= writeData;
            r_n        <= nbytes_f(size);
            r_last_idx <= BW'(ADDR_BYTES) + (write_enable ? BW'(nbytes_f(size)) : BW'(0));
        end
    end

    // Frame byte that follows the byte currently on the line.
    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < ADDR_BYTES; i++)
            w_tx_byte = (w_nxt_idx == BW'(i + 1)) ? r_addr[8*i +: 8] : w_tx_byte;
        for (int i = 0; i < DATA_BYTES; i++)
            w_tx_byte = (w_nxt_idx == BW'(i + 1 + ADDR_BYTES)) ? r_wdata[8*i +: 8] : w_tx_byte;
    end

    // TX serialiser. The 9-bit shift register holds the data bits and then
    // the stop bit. The next start bit follows the stop bit with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx       <= 1'b1;
            r_tx_shift <= 9'h1FF;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_idx   <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_tx       <= 1'b0;
            r_tx_shift <= {1'b1, w_cmd_in};
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_idx   <= '0;
        end else if (r_state == S_SEND) begin
            if (!w_bit_end) begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end else if (r_tx_bit != 4'd9) begin
                r_tx_cnt   <= '0;
                r_tx       <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
            end else if (r_tx_idx == r_last_idx) begin
                r_tx_cnt <= '0;
                r_tx     <= 1'b1;
            end else begin
                r_tx_cnt   <= '0;
                r_tx       <= 1'b0;
                r_tx_shift <= {1'b1, w_tx_byte};
                r_tx_bit   <= 4'd0;
                r_tx_idx   <= w_nxt_idx;
            end
        end else begin
            r_tx <= 1'b1;
        end
    end

    // RX synchroniser and deserialiser. It always runs. Only the WAIT_RX
    // logic consumes its strobes, so bytes in other states are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (!r_rx_busy) begin
                r_rx_busy <= r_rx_s3 & ~r_rx_s2;
                r_rx_cnt  <= '0;
                r_rx_bit  <= 4'd0;
            end else if (!w_rx_tick) begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end else begin
                r_rx_cnt <= '0;
                if (r_rx_bit == 4'd0) begin
                    // A start bit that is high at mid-bit is a glitch.
                    r_rx_busy <= ~r_rx_s2;
                    r_rx_bit  <= 4'd1;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                end else begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end
            end
        end
    end

    // Current load buffer with the newly received byte placed in its slot.
    always_comb begin
        w_ld_raw = r_rx_buf;
        for (int i = 0; i < DATA_BYTES; i++)
            w_ld_raw[8*i +: 8] = (r_rx_idx == 3'(i)) ? r_rx_shift : w_ld_raw[8*i +: 8];
    end

    // Reply byte collection and the inactivity timeout for WAIT_RX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_idx <= 3'd0;
            r_rx_buf <= '0;
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_RX) begin
            r_rx_idx <= 3'd0;
            r_rx_buf <= '0;
            r_to_cnt <= '0;
        end else if (w_byte_ok) begin
            r_rx_idx <= r_rx_idx + 3'd1;
            r_rx_buf <= w_ld_raw;
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // Registered status outputs and the load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_done  <= 1'b0;
            r_mem_error <= 1'b0;
            r_busy      <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_mem_done  <= w_fin;
            r_mem_error <= w_fin & w_fin_err;
            r_busy      <= (w_state_next != S_IDLE);
            if (w_fin && !w_fin_err && !r_rw)
                r_rdata <= extend_f(w_ld_raw, r_n, r_sign);
        end
    end
endmodule
